id_ex_ctrl_pipe: RTL and testbench

ID/EX pipeline stage for the 5-stage MIPS CPU, directly downstream of the single-cycle control decoder. It registers the decoder's control bundle with the ID-stage operands into the EX stage, detects load-use hazards against the instruction currently in EX, and inserts bubbles on a hazard or a taken-branch/jump flush. It also keeps a saturating count of inserted bubbles for performance debug.

---
 rtl/id_ex_ctrl_pipe.sv | 178 +++++++++++++++++
 tb/tb_id_ex_ctrl_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX pipeline register: registers the decoder control bundle and ID operands into EX,
// detects load-use hazards against the load in EX, and inserts bubbles on hazard or flush.
module id_ex_ctrl_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             id_valid,
    input  logic             id_RegDst,
    input  logic             id_ALUSrc,
    input  logic             id_MemtoReg,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_Branch,
    input  logic             id_Jump,
    input  logic [1:0]       id_ALUOp,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [31:0]      id_rd1,
    input  logic [31:0]      id_rd2,
    input  logic [31:0]      id_imm,
    input  logic [31:0]      id_pc4,

    input  logic             ex_flush,

    output logic             ex_valid,
    output logic             ex_RegDst,
    output logic             ex_ALUSrc,
    output logic             ex_MemtoReg,
    output logic             ex_RegWrite,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_Branch,
    output logic             ex_Jump,
    output logic [1:0]       ex_ALUOp,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [31:0]      ex_rd1,
    output logic [31:0]      ex_rd2,
    output logic [31:0]      ex_imm,
    output logic [31:0]      ex_pc4,

    output logic             stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             r_valid;
    logic             r_RegDst;
    logic             r_ALUSrc;
    logic             r_MemtoReg;
    logic             r_RegWrite;
    logic             r_MemRead;
    logic             r_MemWrite;
    logic             r_Branch;
    logic             r_Jump;
    logic [1:0]       r_ALUOp;
    logic [4:0]       r_rs;
    logic [4:0]       r_rt;
    logic [4:0]       r_rd;
    logic [31:0]      r_rd1;
    logic [31:0]      r_rd2;
    logic [31:0]      r_imm;
    logic [31:0]      r_pc4;
    logic [CNT_W-1:0] r_bubbleCnt;

    logic             w_usesRs;
    logic             w_usesRt;
    logic             w_rsMatch;
    logic             w_rtMatch;
    logic             w_hz;
    logic             w_countBubble;
    logic             w_load;
    logic             w_cntSat;

    // Jumps carry no register operand; rt is read by R-format, stores and branches.
    assign w_usesRs      = ~id_Jump;
    assign w_usesRt      = id_RegDst | id_MemWrite | (id_Branch & ~id_Jump);
    assign w_rsMatch     = w_usesRs & (r_rt == id_rs);
    assign w_rtMatch     = w_usesRt & (r_rt == id_rt);
    assign w_hz          = r_valid & r_MemRead & id_valid & (r_rt != 5'd0)
                           & (w_rsMatch | w_rtMatch);

    // A flush already kills the ID slot, so holding upstream would be pointless.
    assign stall         = w_hz & ~ex_flush;
    assign w_countBubble = ex_flush | w_hz;
    assign w_load        = ~w_countBubble & id_valid;
    assign w_cntSat      = &r_bubbleCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_RegDst   <= 1'b0;
            r_ALUSrc   <= 1'b0;
            r_MemtoReg <= 1'b0;
            r_RegWrite <= 1'b0;
            r_MemRead  <= 1'b0;
            r_MemWrite <= 1'b0;
            r_Branch   <= 1'b0;
            r_Jump     <= 1'b0;
            r_ALUOp    <= 2'b00;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_RegDst   <= id_RegDst;
            r_ALUSrc   <= id_ALUSrc;
            r_MemtoReg <= id_MemtoReg;
            r_RegWrite <= id_RegWrite;
            r_MemRead  <= id_MemRead;
            r_MemWrite <= id_MemWrite;
            r_Branch   <= id_Branch;
            r_Jump     <= id_Jump;
            r_ALUOp    <= id_ALUOp;
        end else begin
            r_valid    <= 1'b0;
            r_RegDst   <= 1'b0;
            r_ALUSrc   <= 1'b0;
            r_MemtoReg <= 1'b0;
            r_RegWrite <= 1'b0;
            r_MemRead  <= 1'b0;
            r_MemWrite <= 1'b0;
            r_Branch   <= 1'b0;
            r_Jump     <= 1'b0;
            r_ALUOp    <= 2'b00;
        end
    end

    // Specifiers and operands load unconditionally; a bubble makes them don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs  <= 5'd0;
            r_rt  <= 5'd0;
            r_rd  <= 5'd0;
            r_rd1 <= 32'd0;
            r_rd2 <= 32'd0;
            r_imm <= 32'd0;
            r_pc4 <= 32'd0;
        end else begin
            r_rs  <= id_rs;
            r_rt  <= id_rt;
            r_rd  <= id_rd;
            r_rd1 <= id_rd1;
            r_rd2 <= id_rd2;
            r_imm <= id_imm;
            r_pc4 <= id_pc4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubbleCnt <= '0;
        end else if (w_countBubble && !w_cntSat) begin
            r_bubbleCnt <= r_bubbleCnt + 1'b1;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_RegDst   = r_RegDst;
    assign ex_ALUSrc   = r_ALUSrc;
    assign ex_MemtoReg = r_MemtoReg;
    assign ex_RegWrite = r_RegWrite;
    assign ex_MemRead  = r_MemRead;
    assign ex_MemWrite = r_MemWrite;
    assign ex_Branch   = r_Branch;
    assign ex_Jump     = r_Jump;
    assign ex_ALUOp    = r_ALUOp;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_rd       = r_rd;
    assign ex_rd1      = r_rd1;
    assign ex_rd2      = r_rd2;
    assign ex_imm      = r_imm;
    assign ex_pc4      = r_pc4;
    assign bubble_cnt  = r_bubbleCnt;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Self-checking bench for id_ex_ctrl_pipe: directed scenarios then random traffic,
// compared against an instruction-level model of the EX slot and bubble count.
module tb_id_ex_ctrl_pipe;

    // Control bundle order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch Jump ALUOp[1:0]
    localparam logic [9:0] C_RTYPE = 10'b1001_0000_10;
    localparam logic [9:0] C_LW    = 10'b0111_1000_00;
    localparam logic [9:0] C_SW    = 10'b0100_0100_00;
    localparam logic [9:0] C_ORI   = 10'b0101_0000_11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
    logic        id_MemRead, id_MemWrite, id_Branch, id_Jump;
    logic [1:0]  id_ALUOp;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc4;
    logic        ex_flush;

    logic        ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
    logic        ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
    logic [1:0]  ex_ALUOp;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic        stall;
    logic [15:0] bubble_cnt;

    logic        s_valid, s_RegDst, s_ALUSrc, s_MemtoReg, s_RegWrite;
    logic        s_MemRead, s_MemWrite, s_Branch, s_Jump;
    logic [1:0]  s_ALUOp;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [31:0] s_rd1, s_rd2, s_imm, s_pc4;
    logic        s_stall;
    logic [3:0]  s_cnt;

    int totalChecks = 0;
    int badChecks   = 0;

    // Model of the EX slot as "which instruction, if any, sits there"
    logic        mValid;
    logic [9:0]  mCtrl;
    logic [4:0]  mRs, mRt, mRd;
    logic [31:0] mRd1, mRd2, mImm, mPc4;
    int          mBubbles;

    always #5 clk = ~clk;

    id_ex_ctrl_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ALUOp(id_ALUOp),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .ex_flush(ex_flush), .ex_valid(ex_valid),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_ALUOp(ex_ALUOp),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .stall(stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_ctrl_pipe #(.CNT_W(4)) dutSat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ALUOp(id_ALUOp),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .ex_flush(ex_flush), .ex_valid(s_valid),
        .ex_RegDst(s_RegDst), .ex_ALUSrc(s_ALUSrc), .ex_MemtoReg(s_MemtoReg),
        .ex_RegWrite(s_RegWrite), .ex_MemRead(s_MemRead), .ex_MemWrite(s_MemWrite),
        .ex_Branch(s_Branch), .ex_Jump(s_Jump), .ex_ALUOp(s_ALUOp),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_pc4(s_pc4),
        .stall(s_stall), .bubble_cnt(s_cnt)
    );

    function automatic logic [9:0] exCtrl();
        return {ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
                ex_MemWrite, ex_Branch, ex_Jump, ex_ALUOp};
    endfunction

    function automatic logic [9:0] idCtrl();
        return {id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
                id_MemWrite, id_Branch, id_Jump, id_ALUOp};
    endfunction

    // Does the instruction now in ID read the register the load in EX will write?
    function automatic logic modelHazard();
        logic readsRs, readsRt;
        readsRs = !id_Jump;
        readsRt = id_RegDst || id_MemWrite || (id_Branch && !id_Jump);
        if (!(mValid && mCtrl[5] && id_valid) || mRt == 5'd0) return 1'b0;
        return (readsRs && id_rs == mRt) || (readsRt && id_rt == mRt);
    endfunction

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setInstr(input logic v, input logic [9:0] ctrl,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic fl);
        id_valid = v;
        {id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
         id_MemWrite, id_Branch, id_Jump, id_ALUOp} = ctrl;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_rd1   = $urandom;
        id_rd2   = $urandom;
        id_imm   = $urandom;
        id_pc4   = $urandom;
        ex_flush = fl;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        checkOutput({tag, "_ctrl"}, {22'd0, exCtrl()}, 32'd0);
        checkOutput({tag, "_spec"}, {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
        checkOutput({tag, "_ops"}, ex_rd1 | ex_rd2 | ex_imm | ex_pc4, 32'd0);
        checkOutput({tag, "_cnt"}, {16'd0, bubble_cnt}, 32'd0);
        checkOutput({tag, "_cnt4"}, {28'd0, s_cnt}, 32'd0);
        checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd0);
    endtask

    // One pipeline step: check stall on the held ID inputs, clock, advance model, check EX.
    task automatic applyStimulus();
        logic hzExp;
        hzExp = modelHazard();
        #1;
        checkOutput("stall", {31'd0, stall}, {31'd0, hzExp && !ex_flush});
        checkOutput("stall4", {31'd0, s_stall}, {31'd0, hzExp && !ex_flush});
        @(posedge clk);
        if (ex_flush || hzExp) begin
            mBubbles++;
            mValid = 1'b0;
            mCtrl  = '0;
        end else if (!id_valid) begin
            mValid = 1'b0;
            mCtrl  = '0;
        end else begin
            mValid = 1'b1;
            mCtrl  = idCtrl();
            mRs = id_rs; mRt = id_rt; mRd = id_rd;
            mRd1 = id_rd1; mRd2 = id_rd2; mImm = id_imm; mPc4 = id_pc4;
        end
        #1;
        checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, mValid});
        checkOutput("ex_ctrl", {22'd0, exCtrl()}, {22'd0, mCtrl});
        checkOutput("bubble_cnt", {16'd0, bubble_cnt}, sat(mBubbles, 65535));
        checkOutput("bubble_cnt4", {28'd0, s_cnt}, sat(mBubbles, 15));
        if (mValid) begin
            checkOutput("ex_spec", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, mRs, mRt, mRd});
            checkOutput("ex_rd1", ex_rd1, mRd1);
            checkOutput("ex_rd2", ex_rd2, mRd2);
            checkOutput("ex_imm", ex_imm, mImm);
            checkOutput("ex_pc4", ex_pc4, mPc4);
        end
    endtask

    task automatic modelReset();
        mValid = 1'b0; mCtrl = '0; mBubbles = 0;
        mRs = '0; mRt = '0; mRd = '0;
        mRd1 = '0; mRd2 = '0; mImm = '0; mPc4 = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        setInstr(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        modelReset();
        #12;
        checkAllZero("reset");
        rst_n = 1'b1;

        setInstr(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
        id_rd1 = 32'h11;
        id_rd2 = 32'h22;
        applyStimulus();

        setInstr(1'b1, C_LW, 5'd1, 5'd9, 5'd0, 1'b0);
        applyStimulus();
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        modelReset();
        #3;
        rst_n = 1'b1;

        // Load-use on rs: one bubble, then ADD loads with ID held
        setInstr(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 1'b0);
        applyStimulus();
        setInstr(1'b1, C_RTYPE, 5'd5, 5'd6, 5'd8, 1'b0);
        applyStimulus();
        checkOutput("lu_cnt_is_1", {16'd0, bubble_cnt}, 32'd1);
        applyStimulus();

        // rt=0 never hazards; ORI ignores rt; SW does read rt
        setInstr(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 1'b0);
        applyStimulus();
        setInstr(1'b1, C_RTYPE, 5'd0, 5'd4, 5'd8, 1'b0);
        applyStimulus();
        setInstr(1'b1, C_LW, 5'd1, 5'd7, 5'd0, 1'b0);
        applyStimulus();
        setInstr(1'b1, C_ORI, 5'd3, 5'd7, 5'd0, 1'b0);
        applyStimulus();
        setInstr(1'b1, C_LW, 5'd1, 5'd7, 5'd0, 1'b0);
        applyStimulus();
        setInstr(1'b1, C_SW, 5'd2, 5'd7, 5'd0, 1'b0);
        applyStimulus();

        // Flush together with a hazard, then flush alone
        setInstr(1'b1, C_LW, 5'd1, 5'd4, 5'd0, 1'b0);
        applyStimulus();
        setInstr(1'b1, C_RTYPE, 5'd4, 5'd2, 5'd8, 1'b1);
        applyStimulus();
        setInstr(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3, 1'b1);
        applyStimulus();

        // Invalid slot with undriven control
        setInstr(1'b0, 10'bx, 5'd1, 5'd2, 5'd3, 1'b0);
        applyStimulus();

        for (int i = 0; i < 20; i++) begin
            setInstr(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3, 1'b1);
            applyStimulus();
        end
        checkOutput("sat_cnt4", {28'd0, s_cnt}, 32'd15);

        for (int i = 0; i < 400; i++) begin
            logic [9:0] ctrl;
            ctrl = 10'($urandom);
            if ($urandom_range(0, 2) == 0) ctrl = C_LW;
            setInstr($urandom_range(0, 7) != 0, ctrl,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 31)), $urandom_range(0, 9) == 0);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
